// File: rtl/lut3_pkg.sv
// Shared types and constants for the serially loadable 3-input LUT.
// Included by lut3_mem and lut3_loader.
package lut3_pkg;
  localparam int TABLE_W = 8;
  localparam int CNT_W   = 4;

  localparam logic [TABLE_W-1:0] DEFAULT_TABLE = 8'h45;
  localparam logic [CNT_W-1:0]   CNT_LAST      = CNT_W'(TABLE_W - 1);
  localparam logic [CNT_W-1:0]   CNT_PAR       = CNT_W'(TABLE_W);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_CHECK,
    ST_COMMIT
  } state_t;
endpackage

// File: rtl/lut3_mem.sv
// Truth-table register with a registered lookup.
// The read always uses the table value held before the edge.
module lut3_mem
  import lut3_pkg::*;
#(
  parameter logic [TABLE_W-1:0] INIT = DEFAULT_TABLE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [TABLE_W-1:0] wdata,
  input  logic [2:0]         addr,
  output logic               rdata
);
  logic [TABLE_W-1:0] r_table;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_table <= INIT;
      rdata   <= 1'b0;
    end else begin
      rdata <= r_table[addr];
      if (we) r_table <= wdata;
    end
  end
endmodule

// File: rtl/lut3_loader.sv
// 3-input LUT whose truth table is reloaded serially (entry 0 first).
// Define LUT3_LOADER_PARITY_EN to require a 9th even-parity bit per load.
module lut3_loader
  import lut3_pkg::*;
#(
  parameter logic [TABLE_W-1:0] INIT_TABLE = DEFAULT_TABLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_start,
  input  logic cfg_valid,
  input  logic cfg_bit,
  output logic cfg_ready,
  output logic busy,
  output logic done,
  output logic err,
  input  logic A,
  input  logic B,
  input  logic C,
  output logic F
);
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [TABLE_W-1:0] r_shadow;
  logic               r_cfg_ready;
  logic               r_busy;
  logic               r_done;
  logic               w_accept;
  logic               w_we;

  assign w_accept  = cfg_valid & r_cfg_ready;
  assign w_we      = (r_state == ST_COMMIT);
  assign cfg_ready = r_cfg_ready;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef LUT3_LOADER_PARITY_EN
  logic r_par;
  logic r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // Outputs are registered together with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_cfg_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef LUT3_LOADER_PARITY_EN
      r_par       <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef LUT3_LOADER_PARITY_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        ST_RUN: begin
          if (cfg_start) begin
            r_state     <= ST_LOAD;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (cfg_start) begin
            r_cnt    <= '0;
            r_shadow <= '0;
          end else if (w_accept) begin
`ifdef LUT3_LOADER_PARITY_EN
            if (r_cnt == CNT_PAR) begin
              r_par       <= cfg_bit;
              r_state     <= ST_CHECK;
              r_cfg_ready <= 1'b0;
            end else begin
              r_shadow[r_cnt[2:0]] <= cfg_bit;
              r_cnt                <= r_cnt + CNT_W'(1);
            end
`else
            r_shadow[r_cnt[2:0]] <= cfg_bit;
            r_cnt                <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
              r_state     <= ST_COMMIT;
              r_cfg_ready <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end
`endif
          end
        end
`ifdef LUT3_LOADER_PARITY_EN
        ST_CHECK: begin
          if (cfg_start) begin
            r_state     <= ST_LOAD;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_cfg_ready <= 1'b1;
          end else if ((^r_shadow) == r_par) begin
            r_state <= ST_COMMIT;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  lut3_mem #(.INIT(INIT_TABLE)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .wdata (r_shadow),
    .addr  ({A, B, C}),
    .rdata (F)
  );
endmodule

// File: tb/tb_lut3_loader.sv
// Directed/randomized bench for lut3_loader against a table-level model.
// Honours LUT3_LOADER_PARITY_EN the same way as the design.
module tb_lut3_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cfg_start = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_bit = 1'b0;
  logic cfg_ready, busy, done, err;
  logic A = 1'b0, B = 1'b0, C = 1'b0;
  logic F;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model_tbl = 8'h45;

  lut3_loader dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .cfg_ready(cfg_ready), .busy(busy), .done(done),
    .err(err), .A(A), .B(B), .C(C), .F(F)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; F must reflect the table held before that edge.
  task automatic tick();
    logic exp_f;
    exp_f = model_tbl[{A, B, C}];
    @(posedge clk);
    #1;
    chk("F", {7'd0, F}, {7'd0, exp_f});
  endtask

  task automatic tick_r();
    {A, B, C} = 3'($urandom_range(0, 7));
    tick();
  endtask

  task automatic sweep();
    for (int k = 0; k < 8; k++) begin
      {A, B, C} = 3'(k);
      tick();
    end
  endtask

  task automatic send_bit(input logic b);
    for (int g = $urandom_range(0, 2); g > 0; g--) begin
      cfg_valid = 1'b0;
      cfg_bit   = 1'($urandom);
      tick_r();
      chk("ready_gap", {7'd0, cfg_ready}, 8'd1);
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    tick_r();
    cfg_valid = 1'b0;
  endtask

  task automatic send_table(input logic [7:0] data);
    cfg_start = 1'b1;
    tick_r();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    chk("ready_load", {7'd0, cfg_ready}, 8'd1);
    chk("busy_load", {7'd0, busy}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      send_bit(data[i]);
      if (i < 7) chk("done_early", {7'd0, done}, 8'd0);
    end
  endtask

  task automatic finish_idle();
    chk("done_idle", {7'd0, done}, 8'd0);
    chk("busy_idle", {7'd0, busy}, 8'd0);
    chk("ready_idle", {7'd0, cfg_ready}, 8'd0);
    chk("err_idle", {7'd0, err}, 8'd0);
  endtask

`ifdef LUT3_LOADER_PARITY_EN
  task automatic finish_load(input logic [7:0] data, input logic par);
    chk("ready_par", {7'd0, cfg_ready}, 8'd1);
    send_bit(par);
    chk("busy_check", {7'd0, busy}, 8'd1);
    chk("ready_check", {7'd0, cfg_ready}, 8'd0);
    tick_r();
    if ((^data) == par) begin
      chk("done_commit", {7'd0, done}, 8'd1);
      chk("err_commit", {7'd0, err}, 8'd0);
      tick_r();
      model_tbl = data;
    end else begin
      chk("err_reject", {7'd0, err}, 8'd1);
      chk("done_reject", {7'd0, done}, 8'd0);
      tick_r();
    end
    finish_idle();
  endtask
`else
  task automatic finish_load(input logic [7:0] data);
    chk("done_commit", {7'd0, done}, 8'd1);
    chk("busy_commit", {7'd0, busy}, 8'd0);
    tick_r();
    model_tbl = data;
    finish_idle();
  endtask
`endif

  initial begin
    logic [7:0] rnd;
    // Reset assertion and release
    #2 rst_n = 1'b0;
    #4;
    chk("rst_F", {7'd0, F}, 8'd0);
    finish_idle();
    @(negedge clk);
    rst_n = 1'b1;
    sweep();
    chk("sweep_table", model_tbl, 8'h45);

    // cfg_valid in RUN is ignored
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    tick_r();
    chk("run_ready", {7'd0, cfg_ready}, 8'd0);
    chk("run_busy", {7'd0, busy}, 8'd0);
    cfg_valid = 1'b0;
    sweep();

    // All-ones table with valid gaps
    send_table(8'hFF);
`ifdef LUT3_LOADER_PARITY_EN
    finish_load(8'hFF, 1'b0);
`else
    finish_load(8'hFF);
`endif
    sweep();

    // Restart after 5 bits, with a bit offered on the restart cycle
    cfg_start = 1'b1;
    tick_r();
    cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      chk("done_partial", {7'd0, done}, 8'd0);
    end
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    send_table(8'h0F);
`ifdef LUT3_LOADER_PARITY_EN
    finish_load(8'h0F, 1'b0);
`else
    finish_load(8'h0F);
`endif
    sweep();
    chk("restart_table", model_tbl, 8'h0F);

    // Reset in the middle of a load
    cfg_start = 1'b1;
    tick_r();
    cfg_start = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_F", {7'd0, F}, 8'd0);
    finish_idle();
    model_tbl = 8'h45;
    @(negedge clk);
    rst_n = 1'b1;
    sweep();

`ifdef LUT3_LOADER_PARITY_EN
    send_table(8'h81);
    finish_load(8'h81, 1'b0);
    sweep();
    send_table(8'h01);
    finish_load(8'h01, 1'b0);
    sweep();
`endif

    // Random tables
    for (int n = 0; n < 6; n++) begin
      rnd = 8'($urandom);
      send_table(rnd);
`ifdef LUT3_LOADER_PARITY_EN
      finish_load(rnd, 1'($urandom));
`else
      finish_load(rnd);
`endif
      sweep();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
